mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequencing arbiter that shares the core's single memory helper port between instruction fetch and data access (load/store). It accepts one request at a time from either requester under a req/gnt handshake. It drives the RAM read/write index ports from registered copies of the request, and returns read data with a one-cycle `*_rvalid` pulse. It sits between `if_stage`/memory-access logic and the RAM helper inside `SimTop`.

## Interface
Parameters:
- `DATA_W`, 64: data, address and mask width.
- `RAM_LAT`, 1: cycles from the RAM issue cycle to `ram_rdata` valid; legal range 1..8.

Ports:
- `clk` in 1: clock; everything is on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `if_req` in 1: fetch request; held with `if_addr` stable until `if_gnt`.
- `if_addr` in 64: fetch byte address.
- `if_gnt` out 1: fetch request accepted this cycle.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata` out 64: fetched 64-bit word.
- `d_req` in 1: data request; held with its payload stable until `d_gnt`.
- `d_we` in 1: 1 = write, 0 = read.
- `d_addr` in 64: data byte address.
- `d_wdata` in 64: write data.
- `d_wmask` in 64: write bit mask.
- `d_gnt` out 1: data request accepted this cycle.
- `d_rvalid` out 1: one-cycle pulse; read data valid, or write acknowledged.
- `d_rdata` out 64: read data; 0 for writes.
- `ram_en` out 1: RAM read enable.
- `ram_ridx` out 64: read word index.
- `ram_wen` out 1: RAM write enable.
- `ram_widx` out 64: write word index.
- `ram_wdata` out 64: RAM write data.
- `ram_wmask` out 64: RAM write mask.
- `ram_rdata` in 64: RAM read data.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE.** If any request is present, select a winner and assert its `*_gnt` combinationally. Capture owner, we, address, wdata and wmask into registers. Go to ISSUE.
- `*_gnt` is only ever asserted in IDLE, is never asserted for both requesters in the same cycle, and is forced to 0 while `rst` is high.
- **ISSUE.** Lasts exactly one cycle.
  - Read: `ram_en`=1.
  - Write: `ram_wen`=1.
  - Index = (captured address − `PC_START`) >> 3 on both `ram_ridx` and `ram_widx`. Width is 64 and modulo arithmetic applies; no range check.
  - If `RAM_LAT`==1, go to RESP; otherwise go to WAIT with the counter loaded with `RAM_LAT`−2.
- **WAIT.** Decrement the counter each cycle; at 0, go to RESP.
- **Data capture.** Register `ram_rdata` at the edge ending the last cycle of ISSUE/WAIT. For writes, register 0 instead.
- **RESP.** Pulse the owner's `*_rvalid` for one cycle, drive the captured data on its `*_rdata`, then go to IDLE.
- `*_rdata` holds its value until the next RESP for the same requester.
- RAM outputs outside ISSUE: `ram_en`/`ram_wen` = 0; index, data and mask hold their last values.
- Requests arriving outside IDLE wait; requesters must hold them.
- Zero-mask write: full handshake still runs and `ram_wen` still pulses.

## Timing
- Grant in cycle T → ISSUE in T+1 → `*_rvalid` in T+1+`RAM_LAT`.
- Next possible grant: T+2+`RAM_LAT`. Throughput is one transaction per `RAM_LAT`+2 cycles.
- Reset values:
  - State IDLE, counter 0, round-robin pointer = "last granted fetch".
  - All `*_gnt`, `*_rvalid`, `ram_en`, `ram_wen` = 0.
  - All data, index and mask outputs = 0.
- Reset mid-transaction: abort immediately. No `*_rvalid` is produced, and a pending write already issued is not repeated.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin arbitration.
  - On conflict, the requester not granted last wins.
  - The pointer updates on every grant.
- `MEM_ARB_RR_EN` undefined: fixed priority, data always beats fetch; no pointer register exists.
- With a single requester present, both modes grant it immediately.

## Structure
- `PC_START` comes from the shared `defines.v`.
- Add to the shared defines: state encoding constants (`ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`) and owner codes (`ARB_OWN_IF`, `ARB_OWN_D`).
- One sub-module, `arb_pick`: the combinational winner select.
  - Inputs: `if_req`, `d_req`, last-owner flag.
  - Output: one-hot grant.
  - Contains the `MEM_ARB_RR_EN` variants.

## Test plan
- Fetch alone, `RAM_LAT`=1, `PC_START`=0x80000000:
  - Stimulus: `if_addr`=0x80000010, `ram_rdata`=0xDEAD_BEEF_0000_1111.
  - Required: `if_gnt` at T, `ram_en`=1 with `ram_ridx`=2 at T+1, `if_rvalid` with that data at T+2.
- Data write, `d_addr`=0x80000008, `d_wmask`=0xFF:
  - Required: `ram_wen` for exactly 1 cycle with `ram_widx`=1, `d_rvalid`=1 with `d_rdata`=0, no `ram_en` pulse.
- Both requests held continuously, macro undefined:
  - Required: only `d_gnt` ever fires; `if_gnt` stays 0 until `d_req` drops.
- Same stimulus with `MEM_ARB_RR_EN`:
  - Required: grants alternate D, IF, D, IF, spaced every 3 cycles (`RAM_LAT`=1).
- `RAM_LAT`=3 read:
  - Required: grant T, ISSUE T+1, WAIT T+2..T+3, `*_rvalid` at T+4; `ram_rdata` is sampled at the edge ending T+3.
- `rst` pulsed asynchronously during WAIT:
  - Required: all outputs go to 0 immediately, no `*_rvalid` follows, and a new request is granted the first IDLE cycle after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter: FSM states, owner
// codes, grant vector bit positions and the RAM base address.
package mem_port_arbiter_pkg;

  localparam logic [63:0] PC_START = 64'h0000_0000_8000_0000;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_IF = 1'b0,
    ARB_OWN_D  = 1'b1
  } arb_own_e;

  localparam int unsigned ARB_GNT_IF = 0;
  localparam int unsigned ARB_GNT_D  = 1;
  localparam int unsigned ARB_CNT_W  = 3;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational winner select between fetch and data requests.
// MEM_ARB_RR_EN selects round-robin; otherwise data has fixed priority.
module arb_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic       if_req_i,
  input  logic       d_req_i,
`ifdef MEM_ARB_RR_EN
  input  logic       last_if_i,
`endif
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
`ifdef MEM_ARB_RR_EN
    if (if_req_i && d_req_i) begin
      // Conflict goes to whichever side was not granted last.
      if (last_if_i) gnt_o[ARB_GNT_D]  = 1'b1;
      else           gnt_o[ARB_GNT_IF] = 1'b1;
    end else if (d_req_i) begin
      gnt_o[ARB_GNT_D] = 1'b1;
    end else if (if_req_i) begin
      gnt_o[ARB_GNT_IF] = 1'b1;
    end
`else
    if (d_req_i)       gnt_o[ARB_GNT_D]  = 1'b1;
    else if (if_req_i) gnt_o[ARB_GNT_IF] = 1'b1;
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single RAM helper port between fetch and data access, one
// transaction at a time. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_port_arbiter #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] d_wmask,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_en,
  output logic [DATA_W-1:0] ram_ridx,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_widx,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [DATA_W-1:0] ram_wmask,
  input  logic [DATA_W-1:0] ram_rdata
);
  import mem_port_arbiter_pkg::*;

  arb_state_e            state_q, state_d;
  logic [ARB_CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]            pick;
  logic                  gnt_if, gnt_d, any_gnt;
  arb_own_e              own_q;
  logic                  we_q;
  logic [DATA_W-1:0]     idx_q, wdata_q, wmask_q, if_rdata_q, d_rdata_q;

`ifdef MEM_ARB_RR_EN
  logic last_if_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          last_if_q <= 1'b1;
    else if (any_gnt) last_if_q <= gnt_if;
  end
`endif

  arb_pick u_pick (
    .if_req_i  (if_req),
    .d_req_i   (d_req),
`ifdef MEM_ARB_RR_EN
    .last_if_i (last_if_q),
`endif
    .gnt_o     (pick)
  );

  assign gnt_if  = pick[ARB_GNT_IF] & (state_q == ARB_IDLE) & ~rst;
  assign gnt_d   = pick[ARB_GNT_D]  & (state_q == ARB_IDLE) & ~rst;
  assign any_gnt = gnt_if | gnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE:  if (any_gnt) state_d = ARB_ISSUE;
      ARB_ISSUE: begin
        if (RAM_LAT == 1) begin
          state_d = ARB_RESP;
        end else begin
          state_d = ARB_WAIT;
          cnt_d   = ARB_CNT_W'(RAM_LAT - 2);
        end
      end
      ARB_WAIT: begin
        if (cnt_q == '0) state_d = ARB_RESP;
        else             cnt_d   = cnt_q - ARB_CNT_W'(1);
      end
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    if_gnt    = gnt_if;
    d_gnt     = gnt_d;
    ram_en    = 1'b0;
    ram_wen   = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    case (state_q)
      ARB_ISSUE: begin
        ram_en  = ~we_q;
        ram_wen = we_q;
      end
      ARB_RESP: begin
        if_rvalid = (own_q == ARB_OWN_IF);
        d_rvalid  = (own_q == ARB_OWN_D);
      end
      default: ;
    endcase
  end

  // The word index is computed at grant time so the RAM ports hold it afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      own_q      <= ARB_OWN_IF;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (any_gnt) begin
        own_q <= gnt_d ? ARB_OWN_D : ARB_OWN_IF;
        we_q  <= gnt_d & d_we;
        idx_q <= ((gnt_d ? d_addr : if_addr) - DATA_W'(PC_START)) >> 3;
        if (gnt_d) begin
          wdata_q <= d_wdata;
          wmask_q <= d_wmask;
        end
      end
      if (state_d == ARB_RESP) begin
        if (own_q == ARB_OWN_IF) if_rdata_q <= ram_rdata;
        else                     d_rdata_q  <= we_q ? '0 : ram_rdata;
      end
    end
  end

  assign ram_ridx  = idx_q;
  assign ram_widx  = idx_q;
  assign ram_wdata = wdata_q;
  assign ram_wmask = wmask_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter: a RAM_LAT=1 instance for the
// main sequence and a RAM_LAT=3 instance for latency and mid-wait reset.
module tb_mem_port_arbiter;

  localparam logic [63:0] BASE = 64'h8000_0000;

  typedef struct packed {
    logic        own_d;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, if_req3, d_req3;
  logic [63:0] if_addr, d_addr, d_wdata, d_wmask, ram_rdata;

  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, ram_en, ram_wen;
  logic [63:0] if_rdata, d_rdata, ram_ridx, ram_widx, ram_wdata, ram_wmask;
  logic        if_gnt3, if_rvalid3, d_gnt3, d_rvalid3, ram_en3, ram_wen3;
  logic [63:0] if_rdata3, d_rdata3, ram_ridx3, ram_widx3, ram_wdata3, ram_wmask3;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_W(64), .RAM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ram_en(ram_en), .ram_ridx(ram_ridx), .ram_wen(ram_wen), .ram_widx(ram_widx),
    .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
  );

  mem_port_arbiter #(.DATA_W(64), .RAM_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .ram_en(ram_en3), .ram_ridx(ram_ridx3), .ram_wen(ram_wen3), .ram_widx(ram_widx3),
    .ram_wdata(ram_wdata3), .ram_wmask(ram_wmask3), .ram_rdata(ram_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    chk({tag, " sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " d_rvalid"}, 64'(d_rvalid), 64'(e.own_d));
      chk({tag, " if_rvalid"}, 64'(if_rvalid), 64'(!e.own_d));
      chk({tag, " rdata"}, e.own_d ? d_rdata : if_rdata, e.data);
    end
  endtask

  // Called from the ISSUE cycle; expects the response after lat more edges.
  task automatic expect_resp(input string tag, input int lat);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      tick();
      n++;
      seen = if_rvalid || d_rvalid;
    end
    chk({tag, " rvalid_seen"}, 64'(seen), 64'd1);
    chk({tag, " latency"}, 64'(n), 64'(lat));
    if (seen) pop_chk(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  last_c, ngr, wen_cnt, drv_cnt, irv_cnt;
    bit  exp_d;

    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; if_req3 = 1'b0; d_req3 = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0; ram_rdata = '0;
    #1 rst = 1'b1;
    if_req = 1'b1;
    #2;
    chk("rst if_gnt", 64'(if_gnt), 64'd0);
    chk("rst d_gnt", 64'(d_gnt), 64'd0);
    chk("rst ram_en", 64'(ram_en), 64'd0);
    chk("rst ram_wen", 64'(ram_wen), 64'd0);
    chk("rst rvalid", 64'({if_rvalid, d_rvalid}), 64'd0);
    chk("rst ram_ridx", ram_ridx, 64'd0);
    chk("rst ram_wdata", ram_wdata, 64'd0);
    chk("rst ram_wmask", ram_wmask, 64'd0);
    chk("rst if_rdata", if_rdata, 64'd0);
    chk("rst d_rdata", d_rdata, 64'd0);
    chk("rst dut3 gnt", 64'({if_gnt3, d_gnt3}), 64'd0);
    tick(); tick();
    if_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("idle no req if_gnt", 64'(if_gnt), 64'd0);

    // Fetch alone
    if_addr = BASE + 64'h10; ram_rdata = 64'hDEAD_BEEF_0000_1111; if_req = 1'b1;
    #1;
    chk("fetch if_gnt", 64'(if_gnt), 64'd1);
    chk("fetch d_gnt", 64'(d_gnt), 64'd0);
    sb.push_back('{own_d: 1'b0, data: 64'hDEAD_BEEF_0000_1111});
    tick();
    if_req = 1'b0;
    chk("fetch ram_en", 64'(ram_en), 64'd1);
    chk("fetch ram_ridx", ram_ridx, 64'd2);
    chk("fetch ram_wen", 64'(ram_wen), 64'd0);
    chk("fetch gnt in issue", 64'(if_gnt), 64'd0);
    expect_resp("fetch", 1);
    chk("fetch ram_en resp", 64'(ram_en), 64'd0);
    chk("fetch ridx hold", ram_ridx, 64'd2);
    tick();
    chk("fetch rvalid drop", 64'(if_rvalid), 64'd0);
    chk("fetch rdata hold", if_rdata, 64'hDEAD_BEEF_0000_1111);

    // Data write
    d_we = 1'b1; d_addr = BASE + 64'h8; d_wdata = 64'h0123_4567_89AB_CDEF; d_wmask = 64'hFF;
    ram_rdata = 64'hBAD0_BAD0_BAD0_BAD0; d_req = 1'b1;
    #1;
    chk("write d_gnt", 64'(d_gnt), 64'd1);
    chk("write if_gnt", 64'(if_gnt), 64'd0);
    sb.push_back('{own_d: 1'b1, data: 64'd0});
    tick();
    d_req = 1'b0;
    chk("write ram_wen", 64'(ram_wen), 64'd1);
    chk("write ram_en", 64'(ram_en), 64'd0);
    chk("write ram_widx", ram_widx, 64'd1);
    chk("write ram_wdata", ram_wdata, 64'h0123_4567_89AB_CDEF);
    chk("write ram_wmask", ram_wmask, 64'hFF);
    expect_resp("write", 1);
    chk("write wen one cycle", 64'(ram_wen), 64'd0);
    chk("write no ram_en", 64'(ram_en), 64'd0);
    chk("write if_rdata kept", if_rdata, 64'hDEAD_BEEF_0000_1111);
    tick();

    // Data read
    d_we = 1'b0; d_addr = BASE + 64'h20; ram_rdata = 64'h5555_AAAA_1234_0042; d_req = 1'b1;
    #1;
    chk("dread d_gnt", 64'(d_gnt), 64'd1);
    sb.push_back('{own_d: 1'b1, data: 64'h5555_AAAA_1234_0042});
    tick();
    d_req = 1'b0;
    chk("dread ram_en", 64'(ram_en), 64'd1);
    chk("dread ram_ridx", ram_ridx, 64'd4);
    expect_resp("dread", 1);
    tick();

    // Zero-mask write
    d_we = 1'b1; d_addr = BASE + 64'h18; d_wmask = '0; d_req = 1'b1;
    #1;
    chk("zmask d_gnt", 64'(d_gnt), 64'd1);
    sb.push_back('{own_d: 1'b1, data: 64'd0});
    tick();
    d_req = 1'b0;
    chk("zmask ram_wen", 64'(ram_wen), 64'd1);
    chk("zmask ram_wmask", ram_wmask, 64'd0);
    chk("zmask ram_widx", ram_widx, 64'd3);
    expect_resp("zmask", 1);
    tick();

    // Fetch below PC_START: index wraps modulo 2^64
    if_addr = 64'd0; ram_rdata = 64'h0F0F_0F0F_F0F0_F0F0; if_req = 1'b1;
    #1;
    chk("wrap if_gnt", 64'(if_gnt), 64'd1);
    sb.push_back('{own_d: 1'b0, data: 64'h0F0F_0F0F_F0F0_F0F0});
    tick();
    if_req = 1'b0;
    chk("wrap ram_ridx", ram_ridx, 64'h1FFF_FFFF_F000_0000);
    expect_resp("wrap", 1);
    tick();

    // Both requesters held continuously
    d_we = 1'b0; d_addr = BASE; if_addr = BASE + 64'h8; if_req = 1'b1; d_req = 1'b1;
    last_c = -3; ngr = 0;
    for (int c = 0; c < 12; c++) begin
      ram_rdata = 64'hC0DE_0000_0000_0000 | 64'(c);
      #1;
      chk("conflict both gnt", 64'(if_gnt && d_gnt), 64'd0);
      if (if_rvalid || d_rvalid) pop_chk("conflict resp");
      if (if_gnt || d_gnt) begin
`ifdef MEM_ARB_RR_EN
        exp_d = (ngr % 2 == 0);
`else
        exp_d = 1'b1;
`endif
        chk("conflict owner", 64'(d_gnt), 64'(exp_d));
        chk("conflict spacing", 64'(c - last_c), 64'd3);
        last_c = c;
        ngr++;
        sb.push_back('{own_d: d_gnt, data: 64'hC0DE_0000_0000_0000 | 64'(c + 1)});
      end
      tick();
    end
    chk("conflict grant count", 64'(ngr), 64'd4);
    d_req = 1'b0; ram_rdata = 64'h1F1F_2E2E_3D3D_4C4C;
    #1;
    chk("after d drop if_gnt", 64'(if_gnt), 64'd1);
    chk("after d drop d_gnt", 64'(d_gnt), 64'd0);
    sb.push_back('{own_d: 1'b0, data: 64'h1F1F_2E2E_3D3D_4C4C});
    tick();
    if_req = 1'b0;
    expect_resp("after d drop", 1);
    tick();

    // RAM_LAT=3 fetch: data must be taken at the edge ending T+3
    if_addr = BASE + 64'h40; ram_rdata = 64'hAAAA_0000_0000_0001; if_req3 = 1'b1;
    #1;
    chk("lat3 if_gnt", 64'(if_gnt3), 64'd1);
    tick();
    if_req3 = 1'b0;
    chk("lat3 ram_en T+1", 64'(ram_en3), 64'd1);
    chk("lat3 ram_ridx", ram_ridx3, 64'd8);
    ram_rdata = 64'hAAAA_0000_0000_0002;
    tick();
    chk("lat3 ram_en T+2", 64'(ram_en3), 64'd0);
    chk("lat3 rvalid T+2", 64'(if_rvalid3), 64'd0);
    tick();
    chk("lat3 rvalid T+3", 64'(if_rvalid3), 64'd0);
    ram_rdata = 64'h3333_4444_5555_6666;
    tick();
    ram_rdata = 64'hAAAA_0000_0000_0003;
    chk("lat3 rvalid T+4", 64'(if_rvalid3), 64'd1);
    chk("lat3 rdata", if_rdata3, 64'h3333_4444_5555_6666);
    tick();
    chk("lat3 rvalid T+5", 64'(if_rvalid3), 64'd0);

    // Asynchronous reset during WAIT
    d_we = 1'b1; d_addr = BASE + 64'h28; d_wdata = 64'hFEED_FACE_CAFE_0001; d_wmask = '1; d_req3 = 1'b1;
    #1;
    chk("rstw d_gnt", 64'(d_gnt3), 64'd1);
    tick();
    d_req3 = 1'b0;
    chk("rstw ram_wen", 64'(ram_wen3), 64'd1);
    tick();
    #2 rst = 1'b1;
    if_req3 = 1'b1;
    #1;
    chk("rstw ram_wen", 64'(ram_wen3), 64'd0);
    chk("rstw ram_en", 64'(ram_en3), 64'd0);
    chk("rstw ram_widx", ram_widx3, 64'd0);
    chk("rstw ram_wdata", ram_wdata3, 64'd0);
    chk("rstw ram_wmask", ram_wmask3, 64'd0);
    chk("rstw if_rdata", if_rdata3, 64'd0);
    chk("rstw rvalid", 64'({if_rvalid3, d_rvalid3}), 64'd0);
    chk("rstw gnt", 64'({if_gnt3, d_gnt3}), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("rstw regrant", 64'(if_gnt3), 64'd1);
    @(posedge clk); #1;
    if_req3 = 1'b0;
    chk("rstw issue ram_en", 64'(ram_en3), 64'd1);
    wen_cnt = 0; drv_cnt = 0; irv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      wen_cnt += int'(ram_wen3);
      drv_cnt += int'(d_rvalid3);
      irv_cnt += int'(if_rvalid3);
    end
    chk("rstw no write replay", 64'(wen_cnt), 64'd0);
    chk("rstw no d_rvalid", 64'(drv_cnt), 64'd0);
    chk("rstw one if_rvalid", 64'(irv_cnt), 64'd1);

    chk("sb drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
